tff_counter_ctrl: RTL and testbench
===================================

Name: tff_counter_ctrl

Overview:
- Programmable run/stop controller for the T-flip-flop synchronous up-counter datapath.
- Sequences the counter through start, hold, resume and stop, and gates its toggle-enable chain through a prescaler.
- Compares the count against a programmed terminal value and raises wrap/done events in one-shot or periodic mode.
- Sits between a register/CPU-side configuration interface and the counter core; the core is instantiated inside this block.

Parameters:
WIDTH, 4, counter width in bits (T-FF stages)
PRE_W, 4, prescaler width; the counter steps once every (prescale+1) clocks

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cfg_valid  input  1  config request
cfg_ready  output  1  config may be accepted (IDLE or DONE only)
cfg_limit  input  WIDTH  terminal count
cfg_prescale  input  PRE_W  prescale divisor minus 1
cfg_mode  input  1  0 = one-shot, 1 = periodic
start  input  1  level-sampled start/resume request
stop  input  1  level-sampled pause/abort request
count  output  WIDTH  current counter value
busy  output  1  high in RUN or HOLD
tick  output  1  one-cycle pulse on every terminal-count step
done  output  1  one-cycle pulse when a one-shot run completes

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, count = 0, pre_cnt = 0.
  - tick = 0, done = 0, busy = 0, cfg_ready = 1.
  - limit_r = all ones, prescale_r = 0, mode_r = 0.
  - Reset asserted mid-run aborts immediately; no done or tick is produced.
- Config handshake:
  - A config transfers when cfg_valid && cfg_ready; limit_r, prescale_r and mode_r load at that edge.
  - In RUN and HOLD, cfg_valid is ignored and no transfer occurs.
- States: IDLE, RUN, HOLD, DONE.
- IDLE/DONE with start = 1:
  - Go to RUN at that edge; count cleared to 0, pre_cnt cleared.
  - If a config transfers in the same cycle, the new config governs this run.
- RUN, per cycle:
  - step = (pre_cnt == prescale_r).
  - If step: pre_cnt returns to 0 and the counter core's T-chain is enabled (T0 = 1, Ti = AND of lower Q bits). Otherwise pre_cnt increments and the core holds.
- RUN, terminal step (step && count == limit_r):
  - tick = 1 in the following cycle (registered).
  - Periodic: count goes to 0, state stays RUN.
  - One-shot: count holds at limit_r, done = 1 with tick, state goes to DONE.
  - limit_r = 0: every step is terminal and count stays 0.
- Stop and resume:
  - RUN with stop = 1: go to HOLD; count and pre_cnt freeze; the step is suppressed in that cycle.
  - HOLD with start = 1: resume RUN with no clear.
  - HOLD with stop = 1: go to IDLE, count cleared.
- start and stop both high: stop has priority in every state. In IDLE/DONE it is a no-op.
- DONE: count holds at limit_r and busy = 0 until the next start, which restarts from 0.
- Latency:
  - start sampled at edge k puts the block in RUN with count = 0 after edge k.
  - With prescale 0, count = 1 after edge k+1; in general the first increment is at edge k+1+prescale_r.
- Wrap: the datapath wraps naturally at 2^WIDTH-1 → 0. This only occurs if limit_r = 2^WIDTH-1, where it is a terminal step anyway.
- Outputs tick, done, busy and cfg_ready are registered or pure state decodes; no combinational path from inputs to outputs.

Decomposition:
- Shared package tff_ctrl_pkg:
  - state enum (IDLE = 0, RUN = 1, HOLD = 2, DONE = 3)
  - MODE_ONESHOT = 0, MODE_PERIODIC = 1
  - default WIDTH and PRE_W
- Sub-module tff_count_core (parameterised WIDTH):
  - Chain of T-FF stages with async reset, a global enable, and a synchronous clear.
  - T-inputs formed as the AND-chain of lower Q bits.
- The controller FSM, prescaler and comparator stay in tff_counter_ctrl.

Test Plan:
- Reset released; cfg limit = 5, prescale = 0, mode = periodic; start 1 cycle → count 0,1,…,5,0,1,…; tick pulses one cycle after each 5 → 0 step; done never asserts.
- cfg limit = 3, prescale = 2, mode = one-shot; start → count increments every 3 clocks 0→1→2→3; done = tick = 1 once; state DONE; count holds 3; cfg_ready = 1.
- Periodic, limit = 9; stop at count = 4 → count holds 4 for 5 cycles, busy = 1; start → resumes 5,6,…; second stop in HOLD → IDLE, count = 0, busy = 0.
- During RUN assert cfg_valid with limit = 2 → cfg_ready = 0, no transfer, limit stays 9; start and stop together in RUN → HOLD (stop wins).
- limit = 0, prescale = 1, periodic → count stays 0, tick every 2 cycles; limit = 15, prescale = 0 → count 0..15 then 0 with tick at each wrap.
- Assert reset asynchronously mid-run at count = 7 → count = 0, busy = 0, tick = done = 0 immediately; after release, limit_r = 15, and start counts from 0.

Source files
------------

// File: rtl/tff_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : tff_ctrl_pkg
// Brief    : Shared types and defaults for the T-FF counter controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tff_ctrl_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_PRE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

`default_nettype wire

// File: rtl/tff_count_core.sv
//------------------------------------------------------------------------------
// Module   : tff_count_core
// Brief    : Synchronous up-counter built from T-FF stages, enable and clear.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tff_count_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] w_t;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_stage
            logic r_q;

            if (i == 0) begin : g_lsb
                assign w_t[i] = en;
            end else begin : g_upper
                assign w_t[i] = w_t[i-1] & q[i-1];
            end

            // Clear has priority over toggling so a terminal step can restart at 0.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_q <= 1'b0;
                end else if (clr) begin
                    r_q <= 1'b0;
                end else if (w_t[i]) begin
                    r_q <= ~r_q;
                end
            end

            assign q[i] = r_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/tff_counter_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tff_counter_ctrl
// Brief    : Run/hold/stop controller with prescaler and terminal compare.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tff_counter_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic [PRE_W-1:0] cfg_prescale,
    input  logic             cfg_mode,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tick,
    output logic             done
);

    state_t           r_state;
    state_t           w_next;
    logic [PRE_W-1:0] r_pre_cnt;
    logic [WIDTH-1:0] r_limit;
    logic [PRE_W-1:0] r_prescale;
    logic             r_mode;
    logic             r_tick;
    logic             r_done;

    logic             w_en;
    logic             w_clr;
    logic             w_pre_clr;
    logic             w_pre_inc;
    logic             w_tick;
    logic             w_done;
    logic             w_step;
    logic             w_cfg_xfer;

    tff_count_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .reset (reset),
        .en    (w_en),
        .clr   (w_clr),
        .q     (count)
    );

    assign cfg_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign busy       = (r_state == ST_RUN)  || (r_state == ST_HOLD);
    assign tick       = r_tick;
    assign done       = r_done;
    assign w_cfg_xfer = cfg_valid && cfg_ready;
    assign w_step     = (r_pre_cnt == r_prescale);

    always_comb begin
        w_next    = r_state;
        w_en      = 1'b0;
        w_clr     = 1'b0;
        w_pre_clr = 1'b0;
        w_pre_inc = 1'b0;
        w_tick    = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (!stop && start) begin
                    w_next    = ST_RUN;
                    w_clr     = 1'b1;
                    w_pre_clr = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_next = ST_HOLD;
                end else if (w_step) begin
                    w_pre_clr = 1'b1;
                    if (count == r_limit) begin
                        w_tick = 1'b1;
                        if (r_mode == MODE_PERIODIC) begin
                            w_clr = 1'b1;
                        end else begin
                            // One-shot parks the count at the limit.
                            w_done = 1'b1;
                            w_next = ST_DONE;
                        end
                    end else begin
                        w_en = 1'b1;
                    end
                end else begin
                    w_pre_inc = 1'b1;
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    w_next    = ST_IDLE;
                    w_clr     = 1'b1;
                    w_pre_clr = 1'b1;
                end else if (start) begin
                    w_next = ST_RUN;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pre_cnt  <= '0;
            r_limit    <= '1;
            r_prescale <= '0;
            r_mode     <= MODE_ONESHOT;
            r_tick     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_tick  <= w_tick;
            r_done  <= w_done;
            if (w_pre_clr) begin
                r_pre_cnt <= '0;
            end else if (w_pre_inc) begin
                r_pre_cnt <= r_pre_cnt + PRE_W'(1);
            end
            if (w_cfg_xfer) begin
                r_limit    <= cfg_limit;
                r_prescale <= cfg_prescale;
                r_mode     <= cfg_mode;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tff_counter_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_tff_counter_ctrl
// Brief    : Segment table plus per-cycle scoreboard for tff_counter_ctrl.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tff_counter_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_limit;
    logic [3:0] cfg_prescale;
    logic       cfg_mode;
    logic       start;
    logic       stop;
    logic [3:0] count;
    logic       busy;
    logic       tick;
    logic       done;

    tff_counter_ctrl #(.WIDTH(4), .PRE_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_limit    (cfg_limit),
        .cfg_prescale (cfg_prescale),
        .cfg_mode     (cfg_mode),
        .start        (start),
        .stop         (stop),
        .count        (count),
        .busy         (busy),
        .tick         (tick),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] cnt;
        logic       tck;
        logic       dn;
        logic       bsy;
        logic       rdy;
    } obs_t;

    typedef struct {
        logic       cv;
        logic [3:0] lim;
        logic [3:0] pre;
        logic       mode;
        logic       st;
        logic       sp;
        int         n;
        logic [3:0] exp_cnt;
        logic       exp_busy;
    } seg_t;

    seg_t tbl[40];
    int   ntbl = 0;
    obs_t q_exp[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Reference state: 0 idle, 1 run, 2 hold, 3 done
    int m_st, m_cnt, m_pre, m_lim, m_prer, m_mode;

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_pre = 0; m_lim = 15; m_prer = 0; m_mode = 0;
    endtask

    task automatic model_step(output obs_t e);
        bit rdy;
        bit nt;
        bit nd;
        rdy = (m_st == 0) || (m_st == 3);
        nt = 1'b0;
        nd = 1'b0;
        case (m_st)
            0, 3: if (!stop && start) begin m_st = 1; m_cnt = 0; m_pre = 0; end
            1: begin
                if (stop) m_st = 2;
                else if (m_pre == m_prer) begin
                    m_pre = 0;
                    if (m_cnt == m_lim) begin
                        nt = 1'b1;
                        if (m_mode == 1) m_cnt = 0;
                        else begin nd = 1'b1; m_st = 3; end
                    end else m_cnt = (m_cnt + 1) % 16;
                end else m_pre = m_pre + 1;
            end
            default: begin
                if (stop) begin m_st = 0; m_cnt = 0; end
                else if (start) m_st = 1;
            end
        endcase
        if (cfg_valid && rdy) begin
            m_lim = int'(cfg_limit); m_prer = int'(cfg_prescale); m_mode = int'(cfg_mode);
        end
        e.cnt = m_cnt[3:0];
        e.tck = nt;
        e.dn  = nd;
        e.bsy = (m_st == 1) || (m_st == 2);
        e.rdy = (m_st == 0) || (m_st == 3);
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Drives one clock: expected outputs are queued before the edge, compared after.
    task automatic run_cycle();
        obs_t e;
        obs_t g;
        model_step(e);
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        g = {count, tick, done, busy, cfg_ready};
        e = q_exp.pop_front();
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL sb_cycle%0d got cnt=%0d tick=%b done=%b busy=%b rdy=%b expected cnt=%0d tick=%b done=%b busy=%b rdy=%b",
                     cyc, g.cnt, g.tck, g.dn, g.bsy, g.rdy, e.cnt, e.tck, e.dn, e.bsy, e.rdy);
        end
    endtask

    task automatic add(input logic cv, input logic [3:0] lim, input logic [3:0] pre,
                       input logic mode, input logic st, input logic sp, input int n,
                       input logic [3:0] ec, input logic eb);
        tbl[ntbl] = '{cv, lim, pre, mode, st, sp, n, ec, eb};
        ntbl++;
    endtask

    task automatic idle_inputs();
        cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    initial begin
        //   cv lim    pre   md  st  sp   n  cnt  busy
        add(1, 4'd5,  4'd0, 1,  1,  0,   1, 4'd0,  1);  // periodic limit 5
        add(0, 4'd0,  4'd0, 0,  0,  0,   8, 4'd2,  1);  // 1..5,0,1,2
        add(0, 4'd0,  4'd0, 0,  0,  1,   1, 4'd2,  1);  // hold
        add(0, 4'd0,  4'd0, 0,  0,  1,   1, 4'd0,  0);  // abort to idle
        add(1, 4'd3,  4'd2, 0,  1,  0,   1, 4'd0,  1);  // one-shot, /3
        add(0, 4'd0,  4'd0, 0,  0,  0,   9, 4'd3,  1);
        add(0, 4'd0,  4'd0, 0,  0,  0,   3, 4'd3,  0);  // terminal -> DONE
        add(1, 4'd9,  4'd0, 1,  1,  0,   1, 4'd0,  1);  // periodic limit 9
        add(0, 4'd0,  4'd0, 0,  0,  0,   4, 4'd4,  1);
        add(0, 4'd0,  4'd0, 0,  0,  1,   1, 4'd4,  1);
        add(0, 4'd0,  4'd0, 0,  0,  0,   5, 4'd4,  1);
        add(1, 4'd2,  4'd0, 0,  0,  0,   1, 4'd4,  1);  // cfg in HOLD ignored
        add(0, 4'd0,  4'd0, 0,  1,  0,   1, 4'd4,  1);  // resume
        add(1, 4'd2,  4'd0, 0,  0,  0,   2, 4'd6,  1);  // cfg in RUN ignored
        add(0, 4'd0,  4'd0, 0,  1,  1,   1, 4'd6,  1);  // stop wins
        add(0, 4'd0,  4'd0, 0,  0,  1,   1, 4'd0,  0);
        add(0, 4'd0,  4'd0, 0,  1,  0,   1, 4'd0,  1);  // restart, limit still 9
        add(0, 4'd0,  4'd0, 0,  0,  0,  10, 4'd0,  1);
        add(0, 4'd0,  4'd0, 0,  0,  1,   2, 4'd0,  0);
        add(1, 4'd0,  4'd1, 1,  1,  0,   1, 4'd0,  1);  // limit 0, /2
        add(0, 4'd0,  4'd0, 0,  0,  0,   6, 4'd0,  1);
        add(0, 4'd0,  4'd0, 0,  0,  1,   2, 4'd0,  0);
        add(1, 4'd15, 4'd0, 1,  1,  0,   1, 4'd0,  1);  // full range
        add(0, 4'd0,  4'd0, 0,  0,  0,  16, 4'd0,  1);
        add(0, 4'd0,  4'd0, 0,  0,  0,   7, 4'd7,  1);

        reset = 1'b1;
        idle_inputs();
        cfg_limit = 4'd0; cfg_prescale = 4'd0; cfg_mode = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_count", int'(count), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_tick_done", int'({tick, done}), 0);
        check_val("rst_cfg_ready", int'(cfg_ready), 1);
        reset = 1'b0;

        for (int i = 0; i < ntbl; i++) begin
            cfg_valid = tbl[i].cv; cfg_limit = tbl[i].lim; cfg_prescale = tbl[i].pre;
            cfg_mode = tbl[i].mode; start = tbl[i].st; stop = tbl[i].sp;
            for (int k = 0; k < tbl[i].n; k++) run_cycle();
            check_val($sformatf("seg%0d_count", i), int'(count), int'(tbl[i].exp_cnt));
            check_val($sformatf("seg%0d_busy", i), int'(busy), int'(tbl[i].exp_busy));
        end
        idle_inputs();

        // Asynchronous reset mid-cycle while running at count 7
        #2;
        reset = 1'b1;
        #1;
        check_val("async_rst_count", int'(count), 0);
        check_val("async_rst_busy", int'(busy), 0);
        check_val("async_rst_tick_done", int'({tick, done}), 0);
        check_val("async_rst_cfg_ready", int'(cfg_ready), 1);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // start and stop together in IDLE is a no-op
        start = 1'b1; stop = 1'b1;
        run_cycle();
        check_val("idle_start_stop_busy", int'(busy), 0);

        // Default config after reset: limit 15, prescale 0, one-shot
        stop = 1'b0;
        run_cycle();
        start = 1'b0;
        check_val("post_rst_start_count", int'(count), 0);
        repeat (15) run_cycle();
        check_val("post_rst_count15", int'(count), 15);
        run_cycle();
        check_val("post_rst_done", int'(done), 1);
        check_val("post_rst_tick", int'(tick), 1);
        check_val("post_rst_hold_count", int'(count), 15);
        run_cycle();
        check_val("post_rst_done_pulse", int'(done), 0);
        check_val("post_rst_cfg_ready", int'(cfg_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
